// File: rtl/lin_rx_checksum_engine.sv
// -----------------------------------------------------------------------------
// lin_rx_checksum_engine
// Byte-serial LIN receive checksum checker. Accumulates the data bytes (and the
// protected ID in enhanced mode) with LIN carry-wrap addition as they arrive
// from the RX byte deserialiser, then compares the trailing checksum byte
// against the inverted accumulator and reports the verdict.
//
// Ports
//   PCLK           in   clock, rising edge
//   PRESETn        in   async active-low reset
//   frm_start      in   1-cycle pulse, starts a frame (samples pid/len/enh)
//   frm_pid        in   protected identifier, parity bits included
//   frm_len        in   number of data bytes, legal 1..MAX_BYTES
//   frm_enh        in   1 = enhanced checksum (PID included), 0 = classic
//   abort          in   1-cycle pulse, drops the current frame
//   byte_vld       in   byte_data valid this cycle
//   byte_data      in   received byte (data bytes, then checksum byte)
//   busy           out  frame in progress (DATA or CHK)
//   chk_done       out  1-cycle verdict strobe
//   checksum_chkd  out  checksum correct (held)
//   checksum_error out  checksum wrong or length illegal (held)
//   len_error      out  frm_len illegal (held)
//   calc_chksum    out  expected checksum ~acc (held)
//
// State table
//   IDLE | waiting for frm_start
//   DATA | accumulating data bytes
//   CHK  | waiting for the checksum byte
//   DONE | verdict strobe cycle, returns to IDLE
// -----------------------------------------------------------------------------
module lin_rx_checksum_engine #(
  parameter int MAX_BYTES          = 8,
  parameter int LEN_W              = 4,
  parameter bit DIAG_FORCE_CLASSIC = 1'b1
) (
  input  logic             PCLK,
  input  logic             PRESETn,
  input  logic             frm_start,
  input  logic [7:0]       frm_pid,
  input  logic [LEN_W-1:0] frm_len,
  input  logic             frm_enh,
  input  logic             abort,
  input  logic             byte_vld,
  input  logic [7:0]       byte_data,
  output logic             busy,
  output logic             chk_done,
  output logic             checksum_chkd,
  output logic             checksum_error,
  output logic             len_error,
  output logic [7:0]       calc_chksum
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DATA = 2'd1,
    CHK  = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t           state, state_nxt;
  logic [7:0]       acc;
  logic [LEN_W-1:0] cnt;
  logic [LEN_W-1:0] len_r;

  logic             len_legal;
  logic             enh_eff;
  logic             last_data;
  logic [8:0]       sum9;
  logic [7:0]       acc_sum;
  logic             chk_match;

  assign len_legal = (frm_len != '0) && (frm_len <= LEN_W'(MAX_BYTES));

  // Diagnostic frames (PID 0x3C/0x3D) fall back to classic when forced.
  assign enh_eff   = frm_enh & ~(DIAG_FORCE_CLASSIC & (frm_pid[5:1] == 5'b11110));

  assign last_data = (cnt == len_r - LEN_W'(1));

  // End-around carry: the 9th bit is folded back in. acc + byte <= 0x1FE, so
  // the folded result always fits in 8 bits.
  assign sum9      = {1'b0, acc} + {1'b0, byte_data};
  assign acc_sum   = sum9[7:0] + {7'd0, sum9[8]};

  assign chk_match = (byte_data == ~acc);

  // State register
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic; abort > frm_start > byte_vld
  always_comb begin
    state_nxt = state;
    if (abort) begin
      state_nxt = IDLE;
    end else if (frm_start) begin
      state_nxt = len_legal ? DATA : DONE;
    end else begin
      case (state)
        IDLE: state_nxt = IDLE;
        DATA: if (byte_vld && last_data) state_nxt = CHK;
        CHK:  if (byte_vld) state_nxt = DONE;
        DONE: state_nxt = IDLE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  // Output logic
  always_comb begin
    busy     = 1'b0;
    chk_done = 1'b0;
    case (state)
      DATA:    busy = 1'b1;
      CHK:     busy = 1'b1;
      DONE:    chk_done = 1'b1;
      default: ;
    endcase
  end

  // Datapath: accumulator, byte counter, frame length and held verdict
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      acc            <= 8'h00;
      cnt            <= '0;
      len_r          <= '0;
      checksum_chkd  <= 1'b0;
      checksum_error <= 1'b0;
      len_error      <= 1'b0;
      calc_chksum    <= 8'h00;
    end else if (abort) begin
      acc            <= 8'h00;
      cnt            <= '0;
      checksum_chkd  <= 1'b0;
      checksum_error <= 1'b0;
      len_error      <= 1'b0;
      calc_chksum    <= 8'h00;
    end else if (frm_start) begin
      acc            <= (len_legal && enh_eff) ? frm_pid : 8'h00;
      cnt            <= '0;
      len_r          <= frm_len;
      checksum_chkd  <= 1'b0;
      checksum_error <= ~len_legal;
      len_error      <= ~len_legal;
      calc_chksum    <= 8'h00;
    end else if (byte_vld) begin
      if (state == DATA) begin
        acc <= acc_sum;
        cnt <= cnt + LEN_W'(1);
      end else if (state == CHK) begin
        checksum_chkd  <= chk_match;
        checksum_error <= ~chk_match;
        calc_chksum    <= ~acc;
      end
    end
  end

endmodule

// File: tb/tb_lin_rx_checksum_engine.sv
// -----------------------------------------------------------------------------
// tb_lin_rx_checksum_engine
// Directed bench for the LIN receive checksum checker. Inputs change on the
// falling clock edge; outputs are sampled on the falling edge as well, i.e.
// half a cycle after the rising edge that updated them.
// -----------------------------------------------------------------------------
module tb_lin_rx_checksum_engine;

  logic       PCLK = 1'b0;
  logic       PRESETn = 1'b0;
  logic       frm_start = 1'b0;
  logic [7:0] frm_pid = 8'h00;
  logic [3:0] frm_len = 4'd0;
  logic       frm_enh = 1'b0;
  logic       abort = 1'b0;
  logic       byte_vld = 1'b0;
  logic [7:0] byte_data = 8'h00;
  logic       busy;
  logic       chk_done;
  logic       checksum_chkd;
  logic       checksum_error;
  logic       len_error;
  logic [7:0] calc_chksum;

  int tests = 0;
  int fails = 0;

  lin_rx_checksum_engine #(
    .MAX_BYTES(8),
    .LEN_W(4),
    .DIAG_FORCE_CLASSIC(1'b1)
  ) dut (
    .PCLK(PCLK),
    .PRESETn(PRESETn),
    .frm_start(frm_start),
    .frm_pid(frm_pid),
    .frm_len(frm_len),
    .frm_enh(frm_enh),
    .abort(abort),
    .byte_vld(byte_vld),
    .byte_data(byte_data),
    .busy(busy),
    .chk_done(chk_done),
    .checksum_chkd(checksum_chkd),
    .checksum_error(checksum_error),
    .len_error(len_error),
    .calc_chksum(calc_chksum)
  );

  always #5 PCLK = ~PCLK;

  // Verdict vector: {busy, chk_done, chkd, error, len_error, calc}
  function automatic logic [12:0] vrd();
    return {busy, chk_done, checksum_chkd, checksum_error, len_error, calc_chksum};
  endfunction

  task automatic pulse_start(input logic [7:0] pid, input logic [3:0] len, input logic enh);
    frm_start = 1'b1; frm_pid = pid; frm_len = len; frm_enh = enh;
    @(negedge PCLK);
    frm_start = 1'b0;
  endtask

  task automatic send(input logic [7:0] b);
    byte_vld = 1'b1; byte_data = b;
    @(negedge PCLK);
    byte_vld = 1'b0;
  endtask

  task automatic test_reset();
    #2;
    tests++;
    if (vrd() !== 13'h0) begin
      fails++; $display("FAIL reset_outputs: got %h exp 0000", vrd());
    end
    @(negedge PCLK);
    PRESETn = 1'b1;
    @(negedge PCLK);
    tests++;
    if (vrd() !== 13'h0) begin
      fails++; $display("FAIL reset_release_idle: got %h exp 0000", vrd());
    end
  endtask

  task automatic test_classic();
    pulse_start(8'h4A, 4'd2, 1'b0);
    send(8'h4A);
    send(8'h55);
    tests++;
    if (busy !== 1'b1 || chk_done !== 1'b0) begin
      fails++; $display("FAIL classic_busy_in_chk: got busy=%b done=%b exp busy=1 done=0", busy, chk_done);
    end
    send(8'h60);
    tests++;
    if (vrd() !== {5'b01100, 8'h60}) begin
      fails++; $display("FAIL classic_pass: got %h exp %h", vrd(), {5'b01100, 8'h60});
    end
    @(negedge PCLK);
    tests++;
    if (vrd() !== {5'b00100, 8'h60}) begin
      fails++; $display("FAIL classic_hold: got %h exp %h", vrd(), {5'b00100, 8'h60});
    end
  endtask

  task automatic test_enhanced();
    pulse_start(8'h4A, 4'd3, 1'b1);
    send(8'h55); send(8'h93); send(8'hE5);
    send(8'hE6);
    tests++;
    if (vrd() !== {5'b01100, 8'hE6}) begin
      fails++; $display("FAIL enhanced_pass: got %h exp %h", vrd(), {5'b01100, 8'hE6});
    end
    pulse_start(8'h4A, 4'd3, 1'b1);
    send(8'h55); send(8'h93); send(8'hE5);
    send(8'hE7);
    tests++;
    if (vrd() !== {5'b01010, 8'hE6}) begin
      fails++; $display("FAIL enhanced_mismatch: got %h exp %h", vrd(), {5'b01010, 8'hE6});
    end
  endtask

  task automatic test_carry_and_diag();
    pulse_start(8'h00, 4'd2, 1'b0);
    send(8'hFF); send(8'hFF);
    send(8'h00);
    tests++;
    if (vrd() !== {5'b01100, 8'h00}) begin
      fails++; $display("FAIL carry_ff_ff: got %h exp %h", vrd(), {5'b01100, 8'h00});
    end
    pulse_start(8'h3C, 4'd8, 1'b1);
    for (int i = 1; i <= 8; i++) send(8'(i));
    send(8'hDB);
    tests++;
    if (vrd() !== {5'b01100, 8'hDB}) begin
      fails++; $display("FAIL diag_force_classic: got %h exp %h", vrd(), {5'b01100, 8'hDB});
    end
  endtask

  task automatic test_len_error();
    logic [3:0] lens [2];
    logic       seen_busy;
    lens[0] = 4'd0; lens[1] = 4'd9;
    for (int k = 0; k < 2; k++) begin
      seen_busy = 1'b0;
      pulse_start(8'h10, lens[k], 1'b0);
      tests++;
      if (vrd() !== {5'b01011, 8'h00}) begin
        fails++; $display("FAIL len_error_%0d: got %h exp %h", lens[k], vrd(), {5'b01011, 8'h00});
      end
      for (int c = 0; c < 3; c++) begin
        seen_busy |= busy;
        send(8'h33);
      end
      seen_busy |= busy;
      tests++;
      if (vrd() !== {5'b00011, 8'h00} || seen_busy) begin
        fails++; $display("FAIL len_error_%0d_ignore_bytes: got %h busy_seen=%b exp %h busy_seen=0",
                          lens[k], vrd(), seen_busy, {5'b00011, 8'h00});
      end
    end
  endtask

  task automatic test_abort();
    logic seen_done;
    seen_done = 1'b0;
    pulse_start(8'h00, 4'd3, 1'b0);
    send(8'h11);
    abort = 1'b1;
    @(negedge PCLK);
    abort = 1'b0;
    for (int c = 0; c < 4; c++) begin
      seen_done |= chk_done;
      @(negedge PCLK);
    end
    tests++;
    if (vrd() !== 13'h0 || seen_done) begin
      fails++; $display("FAIL abort_mid_frame: got %h done_seen=%b exp 0000 done_seen=0", vrd(), seen_done);
    end
    // Restart with a byte in the same cycle; that byte must be dropped.
    frm_start = 1'b1; frm_pid = 8'h00; frm_len = 4'd2; frm_enh = 1'b0;
    byte_vld = 1'b1; byte_data = 8'h11;
    @(negedge PCLK);
    frm_start = 1'b0; byte_vld = 1'b0;
    send(8'h4A); send(8'h55);
    send(8'h60);
    tests++;
    if (vrd() !== {5'b01100, 8'h60}) begin
      fails++; $display("FAIL start_drops_byte: got %h exp %h", vrd(), {5'b01100, 8'h60});
    end
  endtask

  task automatic test_reset_mid();
    logic seen_done;
    seen_done = 1'b0;
    pulse_start(8'h00, 4'd3, 1'b0);
    send(8'h22);
    #2 PRESETn = 1'b0;
    #1;
    tests++;
    if (vrd() !== 13'h0) begin
      fails++; $display("FAIL async_reset_mid_data: got %h exp 0000", vrd());
    end
    @(negedge PCLK);
    PRESETn = 1'b1;
    send(8'h33); send(8'h44);
    for (int c = 0; c < 4; c++) begin
      seen_done |= chk_done | busy;
      @(negedge PCLK);
    end
    tests++;
    if (seen_done !== 1'b0) begin
      fails++; $display("FAIL reset_no_done_after: got activity=%b exp 0", seen_done);
    end
  endtask

  task automatic test_back_to_back();
    pulse_start(8'h4A, 4'd2, 1'b0);
    send(8'h4A); send(8'h55);
    send(8'h61);
    // DONE cycle of a failing frame: start the next frame right here.
    tests++;
    if (vrd() !== {5'b01010, 8'h60}) begin
      fails++; $display("FAIL b2b_first_verdict: got %h exp %h", vrd(), {5'b01010, 8'h60});
    end
    pulse_start(8'h4A, 4'd3, 1'b1);
    tests++;
    if (busy !== 1'b1 || chk_done !== 1'b0 || checksum_error !== 1'b0) begin
      fails++; $display("FAIL b2b_second_started: got busy=%b done=%b err=%b exp 1 0 0",
                        busy, chk_done, checksum_error);
    end
    send(8'h55); send(8'h93); send(8'hE5);
    send(8'hE6);
    tests++;
    if (vrd() !== {5'b01100, 8'hE6}) begin
      fails++; $display("FAIL b2b_second_verdict: got %h exp %h", vrd(), {5'b01100, 8'hE6});
    end
  endtask

  initial begin
    test_reset();
    test_classic();
    test_enhanced();
    test_carry_and_diag();
    test_len_error();
    test_abort();
    test_reset_mid();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
